// File: rtl/panel_bus_arbiter_if.sv
// panel_bus_arbiter_if: bundles both requester ports, the shared ledpanel write bus and arbiter status.
// Latency: none (wiring only).
// Backpressure: carries rN_valid/rN_ready; the slave modport is the arbiter, the master modport drives requests.
// Ports: r0_*/r1_* requester beats, ctrl_* panel bus, grant, timeout_pulse.
// Optional: PANEL_ARB_STATS_EN adds the r0_beats/r1_beats counters.
interface panel_bus_arbiter_if;
    logic        r0_valid;
    logic        r0_last;
    logic        r0_ready;
    logic [8:0]  r0_en;
    logic [3:0]  r0_wr;
    logic [15:0] r0_addr;
    logic [23:0] r0_wdat;

    logic        r1_valid;
    logic        r1_last;
    logic        r1_ready;
    logic [8:0]  r1_en;
    logic [3:0]  r1_wr;
    logic [15:0] r1_addr;
    logic [23:0] r1_wdat;

    logic [8:0]  ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic [1:0]  grant;
    logic        timeout_pulse;

`ifdef PANEL_ARB_STATS_EN
    logic [31:0] r0_beats;
    logic [31:0] r1_beats;

    modport slave (
        input  r0_valid, r0_last, r0_en, r0_wr, r0_addr, r0_wdat,
        input  r1_valid, r1_last, r1_en, r1_wr, r1_addr, r1_wdat,
        output r0_ready, r1_ready,
        output ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, grant, timeout_pulse,
        output r0_beats, r1_beats
    );

    modport master (
        output r0_valid, r0_last, r0_en, r0_wr, r0_addr, r0_wdat,
        output r1_valid, r1_last, r1_en, r1_wr, r1_addr, r1_wdat,
        input  r0_ready, r1_ready,
        input  ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, grant, timeout_pulse,
        input  r0_beats, r1_beats
    );
`else
    modport slave (
        input  r0_valid, r0_last, r0_en, r0_wr, r0_addr, r0_wdat,
        input  r1_valid, r1_last, r1_en, r1_wr, r1_addr, r1_wdat,
        output r0_ready, r1_ready,
        output ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, grant, timeout_pulse
    );

    modport master (
        output r0_valid, r0_last, r0_en, r0_wr, r0_addr, r0_wdat,
        output r1_valid, r1_last, r1_en, r1_wr, r1_addr, r1_wdat,
        input  r0_ready, r1_ready,
        input  ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, grant, timeout_pulse
    );
`endif
endinterface

// File: rtl/panel_bus_arbiter.sv
// panel_bus_arbiter: round-robin owner of the shared ledpanel write bus for two requesters, atomic bursts.
// Latency: valid in IDLE -> ready next cycle; an accepted beat appears on ctrl_* the cycle after transfer.
// Backpressure: rN_ready is high only while requester N owns the bus; a waiting beat has no side effect.
// Ports: clock, reset (async, active-high), bus (panel_bus_arbiter_if.slave).
// Optional: define PANEL_ARB_STATS_EN to add 32-bit r0_beats/r1_beats transfer counters on the bus.
module panel_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    panel_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state;
    logic        prio;
    logic [15:0] idle_cnt;
    logic        pulse_q;

    logic [8:0]  ctrl_en_q;
    logic [3:0]  ctrl_wr_q;
    logic [15:0] ctrl_addr_q;
    logic [23:0] ctrl_wdat_q;

    logic        xfer0;
    logic        xfer1;
    logic        own_valid;
    logic        own_last;
    logic        other_valid;
    state_t      other_state;
    state_t      handoff_state;

    // ready is a pure decode of the owner register; it never looks at valid.
    assign bus.r0_ready = (state == G0);
    assign bus.r1_ready = (state == G1);
    assign bus.grant    = {state == G1, state == G0};

    assign xfer0 = bus.r0_valid & (state == G0);
    assign xfer1 = bus.r1_valid & (state == G1);

    // Current owner's handshake and where the bus goes when that owner lets go.
    always_comb begin
        own_valid   = 1'b0;
        own_last    = 1'b0;
        other_valid = 1'b0;
        other_state = IDLE;
        case (state)
            G0: begin
                own_valid   = bus.r0_valid;
                own_last    = bus.r0_last;
                other_valid = bus.r1_valid;
                other_state = G1;
            end
            G1: begin
                own_valid   = bus.r1_valid;
                own_last    = bus.r1_last;
                other_valid = bus.r0_valid;
                other_state = G0;
            end
            default: begin
                own_valid   = 1'b0;
                own_last    = 1'b0;
                other_valid = 1'b0;
                other_state = IDLE;
            end
        endcase
        // Waiting requester takes over directly so the bus sees no bubble.
        handoff_state = other_valid ? other_state : IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            idle_cnt <= '0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (bus.r0_valid && (!bus.r1_valid || !prio)) begin
                        state <= G0;
                    end else if (bus.r1_valid) begin
                        state <= G1;
                    end
                end
                G0, G1: begin
                    if (own_valid) begin
                        // A transfer always wins over a timeout due this same cycle.
                        idle_cnt <= '0;
                        if (own_last) begin
                            state    <= handoff_state;
                            prio     <= (state == G0);
                        end
                    end else if (idle_cnt == TIMEOUT_CNT) begin
                        state    <= handoff_state;
                        prio     <= (state == G0);
                        idle_cnt <= '0;
                        pulse_q  <= 1'b1;
                    end else if (idle_cnt != 16'hFFFF) begin
                        // Saturating: a wrap could silently re-arm a stale timeout.
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    // Panel bus: strobes only on a transfer cycle; addr/wdat keep the last beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_en_q   <= '0;
            ctrl_wr_q   <= '0;
            ctrl_addr_q <= '0;
            ctrl_wdat_q <= '0;
        end else if (xfer0) begin
            ctrl_en_q   <= bus.r0_en;
            ctrl_wr_q   <= bus.r0_wr;
            ctrl_addr_q <= bus.r0_addr;
            ctrl_wdat_q <= bus.r0_wdat;
        end else if (xfer1) begin
            ctrl_en_q   <= bus.r1_en;
            ctrl_wr_q   <= bus.r1_wr;
            ctrl_addr_q <= bus.r1_addr;
            ctrl_wdat_q <= bus.r1_wdat;
        end else begin
            ctrl_en_q   <= '0;
            ctrl_wr_q   <= '0;
        end
    end

    assign bus.ctrl_en       = ctrl_en_q;
    assign bus.ctrl_wr       = ctrl_wr_q;
    assign bus.ctrl_addr     = ctrl_addr_q;
    assign bus.ctrl_wdat     = ctrl_wdat_q;
    assign bus.timeout_pulse = pulse_q;

`ifdef PANEL_ARB_STATS_EN
    logic [31:0] r0_beats_q;
    logic [31:0] r1_beats_q;

    // Free-running modulo-2^32 beat counts, in step with the ctrl_* registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r0_beats_q <= '0;
            r1_beats_q <= '0;
        end else begin
            if (xfer0) begin
                r0_beats_q <= r0_beats_q + 32'd1;
            end
            if (xfer1) begin
                r1_beats_q <= r1_beats_q + 32'd1;
            end
        end
    end

    assign bus.r0_beats = r0_beats_q;
    assign bus.r1_beats = r1_beats_q;
`endif

endmodule

// File: tb/tb_panel_bus_arbiter.sv
// tb_panel_bus_arbiter: random and directed traffic from two requesters against a behavioural owner model.
// Latency: n/a.
// Backpressure: each requester holds its beat until it sees ready at a clock edge.
module tb_panel_bus_arbiter;
    localparam int TO = 8;

    typedef struct {
        logic [8:0]  en;
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [23:0] wdat;
        logic        last;
        int          gap;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    panel_bus_arbiter_if pif ();

    panel_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (pif)
    );

    logic        v [2];
    logic        l [2];
    logic [8:0]  en [2];
    logic [3:0]  wr [2];
    logic [15:0] addr [2];
    logic [23:0] wdat [2];

    assign pif.r0_valid = v[0];
    assign pif.r0_last  = l[0];
    assign pif.r0_en    = en[0];
    assign pif.r0_wr    = wr[0];
    assign pif.r0_addr  = addr[0];
    assign pif.r0_wdat  = wdat[0];
    assign pif.r1_valid = v[1];
    assign pif.r1_last  = l[1];
    assign pif.r1_en    = en[1];
    assign pif.r1_wr    = wr[1];
    assign pif.r1_addr  = addr[1];
    assign pif.r1_wdat  = wdat[1];

    beat_t q [2][$];
    bit    acc [2];
    bit    loaded [2];
    int    gapc [2];

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the bus, who is favoured, how long the owner has idled.
    int          m_owner;
    int          m_fav;
    int          m_idle;
    logic [8:0]  e_en;
    logic [3:0]  e_wr;
    logic [15:0] e_addr;
    logic [23:0] e_wdat;
    logic        e_pulse;
    logic [31:0] m_beats [2];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_fav = 0; m_idle = 0;
        e_en = '0; e_wr = '0; e_addr = '0; e_wdat = '0; e_pulse = 1'b0;
        m_beats[0] = '0; m_beats[1] = '0;
    endfunction

    function automatic void model_step();
        int x;
        bit rel;
        x = -1; rel = 1'b0; e_pulse = 1'b0;
        if (m_owner < 0) begin
            if (v[0] && v[1]) m_owner = m_fav;
            else if (v[0])    m_owner = 0;
            else if (v[1])    m_owner = 1;
            m_idle = 0;
        end else begin
            if (v[m_owner]) begin
                x = m_owner; m_idle = 0; rel = l[m_owner];
            end else if (m_idle == TO) begin
                rel = 1'b1; e_pulse = 1'b1;
            end else if (m_idle < 65535) begin
                m_idle++;
            end
            if (rel) begin
                m_fav   = 1 - m_owner;
                m_owner = v[m_fav] ? m_fav : -1;
                m_idle  = 0;
            end
        end
        if (x >= 0) begin
            e_en = en[x]; e_wr = wr[x]; e_addr = addr[x]; e_wdat = wdat[x];
            m_beats[x] = m_beats[x] + 32'd1;
        end else begin
            e_en = '0; e_wr = '0;
        end
    endfunction

    always @(negedge clock) begin
        if (reset) model_reset();
        chk("grant",   32'(pif.grant),     32'({m_owner == 1, m_owner == 0}));
        chk("ready0",  32'(pif.r0_ready),  32'(m_owner == 0));
        chk("ready1",  32'(pif.r1_ready),  32'(m_owner == 1));
        chk("ctrl_en", 32'(pif.ctrl_en),   32'(e_en));
        chk("ctrl_wr", 32'(pif.ctrl_wr),   32'(e_wr));
        chk("ctrl_addr", 32'(pif.ctrl_addr), 32'(e_addr));
        chk("ctrl_wdat", 32'(pif.ctrl_wdat), 32'(e_wdat));
        chk("timeout_pulse", 32'(pif.timeout_pulse), 32'(e_pulse));
`ifdef PANEL_ARB_STATS_EN
        chk("r0_beats", pif.r0_beats, m_beats[0]);
        chk("r1_beats", pif.r1_beats, m_beats[1]);
`endif
        acc[0] = v[0] & pif.r0_ready;
        acc[1] = v[1] & pif.r1_ready;
        if (!reset) model_step();
    end

    function automatic beat_t mk(logic [15:0] a, logic [8:0] e, bit last, int gap);
        beat_t b;
        b.en = e; b.wr = 4'($urandom); b.addr = a; b.wdat = 24'($urandom);
        b.last = last; b.gap = gap;
        return b;
    endfunction

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (acc[r] && q[r].size() > 0) begin
                q[r].delete(0);
                loaded[r] = 1'b0;
            end
            if (q[r].size() > 0) begin
                if (!loaded[r]) begin
                    gapc[r] = q[r][0].gap;
                    loaded[r] = 1'b1;
                end
                if (gapc[r] > 0) begin
                    v[r] = 1'b0;
                    gapc[r]--;
                end else begin
                    v[r] = 1'b1; l[r] = q[r][0].last; en[r] = q[r][0].en;
                    wr[r] = q[r][0].wr; addr[r] = q[r][0].addr; wdat[r] = q[r][0].wdat;
                end
            end else begin
                v[r] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic flush();
        for (int r = 0; r < 2; r++) begin
            q[r].delete();
            loaded[r] = 1'b0;
            gapc[r] = 0;
            v[r] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        flush();
        @(negedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
    endtask

    task automatic drain(int limit);
        int n;
        n = 0;
        while ((q[0].size() > 0 || q[1].size() > 0) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(q[0].size() + q[1].size()), 32'd0);
        repeat (TO + 4) tick();
    endtask

    task automatic push_rand_burst(int r);
        int len;
        bit with_last;
        int gap;
        len = $urandom_range(1, 6);
        with_last = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < len; i++) begin
            if (i == 0) gap = $urandom_range(0, 3);
            else gap = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 12);
            q[r].push_back(mk(16'($urandom), 9'($urandom), with_last && (i == len - 1), gap));
        end
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            v[r] = 1'b0; l[r] = 1'b0; en[r] = '0; wr[r] = '0; addr[r] = '0; wdat[r] = '0;
            loaded[r] = 1'b0; gapc[r] = 0;
        end

        // Reset values.
        #12;
        chk("rst_grant", 32'(pif.grant), 32'd0);
        chk("rst_ready0", 32'(pif.r0_ready), 32'd0);
        chk("rst_ctrl_en", 32'(pif.ctrl_en), 32'd0);
        chk("rst_ctrl_addr", 32'(pif.ctrl_addr), 32'd0);
        chk("rst_pulse", 32'(pif.timeout_pulse), 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;

        // r0 4-beat burst, addr 0..3.
        for (int i = 0; i < 4; i++) q[0].push_back(mk(16'(i), 9'h1FF, i == 3, 0));
        tick(); #2;
        chk("b4_t_ready0", 32'(pif.r0_ready), 32'd0);
        tick(); #2;
        chk("b4_t1_ready0", 32'(pif.r0_ready), 32'd1);
        chk("b4_t1_grant", 32'(pif.grant), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick(); #2;
            chk("b4_addr", 32'(pif.ctrl_addr), 32'(k - 2));
            chk("b4_en", 32'(pif.ctrl_en), 32'h1FF);
        end
        chk("b4_t5_grant", 32'(pif.grant), 32'd0);
        tick(); #2;
        chk("b4_t6_en", 32'(pif.ctrl_en), 32'd0);

        // Contention from reset: r0 first, direct handoff, then r0 wins again.
        do_reset();
        q[0].push_back(mk(16'h0010, 9'h00F, 1'b0, 0));
        q[0].push_back(mk(16'h0011, 9'h00F, 1'b1, 0));
        q[1].push_back(mk(16'h0020, 9'h0F0, 1'b0, 0));
        q[1].push_back(mk(16'h0021, 9'h0F0, 1'b1, 0));
        tick(); #2;
        chk("ct_t_grant", 32'(pif.grant), 32'd0);
        tick(); #2;
        chk("ct_t1_grant", 32'(pif.grant), 32'd1);
        tick(); #2;
        chk("ct_t2_addr", 32'(pif.ctrl_addr), 32'h10);
        tick(); #2;
        chk("ct_t3_addr", 32'(pif.ctrl_addr), 32'h11);
        chk("ct_t3_grant", 32'(pif.grant), 32'd2);
        tick(); #2;
        chk("ct_t4_addr", 32'(pif.ctrl_addr), 32'h20);
        chk("ct_t4_en_nogap", 32'(pif.ctrl_en), 32'h0F0);
        tick(); #2;
        chk("ct_t5_addr", 32'(pif.ctrl_addr), 32'h21);
        chk("ct_t5_grant", 32'(pif.grant), 32'd0);
        q[0].push_back(mk(16'h0030, 9'h001, 1'b1, 0));
        q[1].push_back(mk(16'h0040, 9'h002, 1'b1, 0));
        tick(); tick(); #2;
        chk("ct_t7_grant", 32'(pif.grant), 32'd1);
        drain(100);

        // Timeout: r1 two beats without last then silent; r0 waits from t+5.
        do_reset();
        q[1].push_back(mk(16'h0050, 9'h011, 1'b0, 0));
        q[1].push_back(mk(16'h0051, 9'h011, 1'b0, 0));
        tick(); tick(); tick();
        for (int k = 3; k <= 13; k++) begin
            tick();
            if (k == 4) q[0].push_back(mk(16'h0060, 9'h101, 1'b1, 0));
            #2;
            chk("to_pulse", 32'(pif.timeout_pulse), 32'(k == 12));
            chk("to_grant", 32'(pif.grant), (k < 12) ? 32'd2 : ((k == 12) ? 32'd1 : 32'd0));
        end
        chk("to_addr", 32'(pif.ctrl_addr), 32'h60);
        drain(100);

        // last coincides with the cycle the timeout would fire.
        do_reset();
        q[0].push_back(mk(16'h0070, 9'h003, 1'b0, 0));
        q[0].push_back(mk(16'h0071, 9'h003, 1'b1, TO));
        tick();
        for (int k = 1; k <= 11; k++) begin
            tick(); #2;
            chk("co_pulse", 32'(pif.timeout_pulse), 32'd0);
        end
        chk("co_grant", 32'(pif.grant), 32'd0);
        chk("co_addr", 32'(pif.ctrl_addr), 32'h71);

        // Asynchronous reset mid-burst, then a fresh burst.
        do_reset();
        for (int i = 0; i < 6; i++) q[0].push_back(mk(16'(16'h0100 + i), 9'h1FF, i == 5, 0));
        tick(); tick(); tick();
        #1;
        reset = 1'b1;
        #1;
        chk("ar_ctrl_en", 32'(pif.ctrl_en), 32'd0);
        chk("ar_grant", 32'(pif.grant), 32'd0);
        chk("ar_ready0", 32'(pif.r0_ready), 32'd0);
        chk("ar_ctrl_addr", 32'(pif.ctrl_addr), 32'd0);
        flush();
        @(negedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) q[0].push_back(mk(16'(16'h0200 + i), 9'h1FF, i == 2, 0));
        drain(100);
        chk("ar_after_addr", 32'(pif.ctrl_addr), 32'h202);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < 2; r++)
                if (q[r].size() < 2 && $urandom_range(0, 3) == 0) push_rand_burst(r);
            tick();
        end
        drain(2000);

`ifdef PANEL_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) q[0].push_back(mk(16'(i), 9'h1FF, (i % 10) == 9, 0));
        for (int i = 0; i < 17; i++) q[1].push_back(mk(16'(i), 9'h1FF, i == 16, 0));
        drain(2000);
        chk("st_r0_beats", pif.r0_beats, 32'd300);
        chk("st_r1_beats", pif.r1_beats, 32'd17);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/panel_bus_arbiter.md
# panel_bus_arbiter

Shares the single panel write bus (`ctrl_en`/`ctrl_wr`/`ctrl_addr`/`ctrl_wdat`) that fans out to the nine `ledpanel` instances between two requesters. Requester 0 is the UDP frame writer; requester 1 is a local source such as a test-pattern or status-overlay generator. Bursts are atomic: a requester holds the bus from its first beat through its `last` beat, or until an idle timeout releases it. Grants alternate round-robin, and the bus outputs are registered.

## Interface
- `TIMEOUT`, default 255: consecutive idle cycles (granted, `valid` low) before a grant is forcibly released; legal range 1..65535.
- `clock`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `r0_valid`, `r1_valid`  in  1: requester has a beat.
- `r0_last`, `r1_last`  in  1: beat is the final beat of the burst.
- `r0_ready`, `r1_ready`  out  1: beat accepted this cycle when `valid` is also high.
- `r0_en`, `r1_en`  in  9: panel select mask.
- `r0_wr`, `r1_wr`  in  4: write strobe field, passed through unchanged.
- `r0_addr`, `r1_addr`  in  16: panel address {col,row}.
- `r0_wdat`, `r1_wdat`  in  24: {R,G,B}.
- `ctrl_en`  out  9, `ctrl_wr`  out  4, `ctrl_addr`  out  16, `ctrl_wdat`  out  24: registered bus to the panels.
- `grant`  out  2: one-hot current owner; `2'b00` = idle.
- `timeout_pulse`  out  1: one-cycle pulse when a grant is released by timeout.

## Operation
- Three states: IDLE, G0, G1. `grant` = {state==G1, state==G0}.
- `rN_ready` = (state==GN); it is combinational from state only and never depends on `valid`.
- A beat transfers when `rN_valid & rN_ready`. On a transfer, the next cycle's outputs are `ctrl_en`=`rN_en`, `ctrl_wr`=`rN_wr`, `ctrl_addr`=`rN_addr`, `ctrl_wdat`=`rN_wdat`. In any cycle without a transfer, `ctrl_en` and `ctrl_wr` are 0 and `ctrl_addr`/`ctrl_wdat` hold their previous values.
- `prio` is a 1-bit flag naming the favoured requester; it resets to 0.
- IDLE transitions:
  - Only one requester valid: go to that requester's grant.
  - Both valid: go to `G[prio]`.
  - Neither valid: stay in IDLE.
- GN, on a transfer with `rN_last`:
  - Set `prio` to the other requester.
  - If the other requester's `valid` is high this cycle, go directly to its grant (no IDLE bubble); otherwise go to IDLE.
- GN, on a transfer without `last`: stay in GN.
- Idle counter (16-bit):
  - Clears on entry to GN and on every transfer.
  - Increments on each GN cycle with `rN_valid` low.
  - When it reaches `TIMEOUT`, release the grant with the same handoff rule as `last`, and pulse `timeout_pulse`.
  - The counter saturates; it never wraps.
- A beat presented while its requester is not granted waits with no side effect. Requesters hold their signals stable while `valid & !ready`.
- A `last` asserted on the same cycle the timeout would fire: the transfer wins, the release is normal, and no `timeout_pulse` is generated.

## Timing
- Reset values:
  - state IDLE, `grant`=0, `prio`=0, counter 0.
  - Both `ready` outputs low, `timeout_pulse` 0.
  - `ctrl_en`=0, `ctrl_wr`=0, `ctrl_addr`=0, `ctrl_wdat`=0.
- Arbitration latency: valid rises in IDLE at cycle t; `ready` is high at t+1; the first transfer is at t+1 and appears on `ctrl_*` at t+2.
- Throughput: one beat per cycle within a burst.
- Handoff: the last beat of G0 at cycle t with `r1_valid` high gives `r1_ready` at t+1. The bus carries back-to-back beats from different owners with no gap.
- Timeout: G0 entered at t with `r0_valid` low throughout gives `grant` change and `timeout_pulse` at t+TIMEOUT+1.
- Reset mid-burst: outputs return to reset values immediately (asynchronous). The burst is abandoned, and the requester must restart it.

## Configuration
- `PANEL_ARB_STATS_EN`: when defined, adds outputs `r0_beats` and `r1_beats` (32-bit each), incremented on each transfer of the respective requester. They wrap modulo 2^32, reset to 0, and update on the same cycle the `ctrl_*` registers do.
- Without the macro, these ports and counters do not exist and all other behaviour is identical.

## Test plan
- Reset release, r0 sends a 4-beat burst, addr 0x0000..0x0003, en=0x1FF → `r0_ready` at t+1; `ctrl_addr` 0,1,2,3 on t+2..t+5; `grant` back to 0 at t+5; `ctrl_en`=0 afterwards.
- Both requesters raise valid in the same cycle from IDLE after reset → G0 first (`prio`=0); after r0's `last`, direct handoff to G1 with no `ctrl_en`=0 gap; then the next contention goes to r0.
- r1 is granted, sends 2 beats without `last`, then drops valid; TIMEOUT=8 → `timeout_pulse` exactly 9 cycles after the last transfer; `grant` moves to G0 if `r0_valid` is high, else to idle.
- `last` and the timeout coincide in the same cycle → normal release, `timeout_pulse` stays 0.
- `reset` asserted asynchronously mid-burst (between edges) → `ctrl_en`, `grant`, `ready` go to 0 before the next edge; after release, a new r0 burst completes correctly.
- With `PANEL_ARB_STATS_EN`: 300 r0 beats and 17 r1 beats → `r0_beats`=300, `r1_beats`=17. Preloading a counter to 0xFFFFFFFF and sending one beat wraps it to 0.
